// File: rtl/exec_sequencer_pkg.sv
// Shared encodings for the exec_sequencer run-control block.
package exec_sequencer_pkg;

    localparam int unsigned RUN_STATE_W  = 2;
    localparam int unsigned HALT_CAUSE_W = 3;
    localparam int unsigned CMD_OP_W     = 2;
    localparam int unsigned INSN_W       = 32;
    localparam int unsigned RETIRE_W     = 32;

    localparam logic [INSN_W-1:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [RUN_STATE_W-1:0] {
        RS_HALT = 2'b00,
        RS_RUN  = 2'b01,
        RS_STEP = 2'b10
    } run_state_e;

    typedef enum logic [HALT_CAUSE_W-1:0] {
        HC_NONE      = 3'd0,
        HC_HOST      = 3'd1,
        HC_BP        = 3'd2,
        HC_EBREAK    = 3'd3,
        HC_STEP_DONE = 3'd4
    } halt_cause_e;

    typedef enum logic [CMD_OP_W-1:0] {
        OP_HALT = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_CLR  = 2'b11
    } cmd_op_e;

endpackage

// File: rtl/exec_sequencer_bp_unit.sv
// Hardware PC breakpoint: address/enable registers, resume-skip flag and hit compare.
module exec_bp_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bp_wr,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              set_skip,
    input  logic              commit,
    output logic              bp_hit
);

    logic [ADDR_W-1:0] bp_q;
    logic              bp_en_q;
    logic              skip_q;

    // A write only takes effect from the next cycle; this cycle compares the old value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bp_q    <= '0;
            bp_en_q <= 1'b0;
        end else if (bp_wr) begin
            bp_q    <= bp_addr;
            bp_en_q <= bp_en_in;
        end
    end

    // Skip lets a resume from the breakpoint PC execute that instruction once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skip_q <= 1'b0;
        end else if (set_skip) begin
            skip_q <= 1'b1;
        end else if (commit) begin
            skip_q <= 1'b0;
        end
    end

    assign bp_hit = bp_en_q & (pc_in == bp_q) & ~skip_q;

endmodule

// File: rtl/exec_sequencer.sv
// Run-control sequencer: host run/halt/step, PC breakpoint and EBREAK trapping.
// Optional retired-instruction counter built when EXEC_SEQ_RETIRE_CNT_EN is defined.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STEP_W       = 8,
    parameter bit          RUN_ON_RESET = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CMD_OP_W-1:0]     cmd_op,
    input  logic [STEP_W-1:0]       cmd_arg,
    input  logic                    bp_wr,
    input  logic [ADDR_W-1:0]       bp_addr,
    input  logic                    bp_en_in,
    input  logic [ADDR_W-1:0]       pc_in,
    input  logic [INSN_W-1:0]       instr_in,
    output logic                    pc_en,
    output logic                    wr_gate,
    output logic                    halted,
    output logic [RUN_STATE_W-1:0]  run_state,
    output logic [HALT_CAUSE_W-1:0] halt_cause,
    output logic [RETIRE_W-1:0]     retired_cnt
);

    localparam run_state_e RESET_STATE = RUN_ON_RESET ? RS_RUN : RS_HALT;

    run_state_e        state_q, state_d;
    halt_cause_e       cause_q, cause_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              set_skip;
    logic              ebreak_hit;
    logic              bp_hit;
    logic              cmd_fire;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
    logic              retire_clr;
    logic [RETIRE_W-1:0] retire_q;
`endif

    exec_bp_unit #(
        .ADDR_W (ADDR_W)
    ) u_bp (
        .clock    (clock),
        .reset    (reset),
        .bp_wr    (bp_wr),
        .bp_addr  (bp_addr),
        .bp_en_in (bp_en_in),
        .pc_in    (pc_in),
        .set_skip (set_skip),
        .commit   (pc_en),
        .bp_hit   (bp_hit)
    );

    assign ebreak_hit = (instr_in == EBREAK_INSN);
    assign cmd_ready  = (state_q != RS_STEP);
    assign cmd_fire   = cmd_valid & cmd_ready;
    // A halting instruction never commits; a host HALT does not block this cycle.
    assign pc_en      = (state_q != RS_HALT) & ~ebreak_hit & ~bp_hit;
    assign wr_gate    = pc_en;
    assign halted     = (state_q == RS_HALT);
    assign run_state  = state_q;
    assign halt_cause = cause_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            cause_q <= HC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        set_skip = 1'b0;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        retire_clr = 1'b0;
`endif
        case (state_q)
            RS_HALT: begin
                if (cmd_fire) begin
                    case (cmd_op_e'(cmd_op))
                        OP_RUN: begin
                            state_d  = RS_RUN;
                            cause_d  = HC_NONE;
                            set_skip = 1'b1;
                        end
                        OP_STEP: begin
                            state_d  = RS_STEP;
                            cause_d  = HC_NONE;
                            set_skip = 1'b1;
                            cnt_d    = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
                        end
                        OP_CLR: begin
                            cause_d = HC_NONE;
`ifdef EXEC_SEQ_RETIRE_CNT_EN
                            retire_clr = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            RS_RUN: begin
                if (ebreak_hit) begin
                    state_d = RS_HALT;
                    cause_d = HC_EBREAK;
                end else if (bp_hit) begin
                    state_d = RS_HALT;
                    cause_d = HC_BP;
                end else if (cmd_fire && (cmd_op_e'(cmd_op) == OP_HALT)) begin
                    state_d = RS_HALT;
                    cause_d = HC_HOST;
                end
            end
            RS_STEP: begin
                if (ebreak_hit) begin
                    state_d = RS_HALT;
                    cause_d = HC_EBREAK;
                    cnt_d   = '0;
                end else if (bp_hit) begin
                    state_d = RS_HALT;
                    cause_d = HC_BP;
                    cnt_d   = '0;
                end else if (cnt_q == STEP_W'(1)) begin
                    state_d = RS_HALT;
                    cause_d = HC_STEP_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            default: begin
                state_d = RS_HALT;
            end
        endcase
    end

`ifdef EXEC_SEQ_RETIRE_CNT_EN
    // Counts commits, wrapping modulo 2^32; CLR in HALT zeroes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_q <= '0;
        end else if (retire_clr) begin
            retire_q <= '0;
        end else if (pc_en) begin
            retire_q <= retire_q + RETIRE_W'(1);
        end
    end
    assign retired_cnt = retire_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (honours EXEC_SEQ_RETIRE_CNT_EN).
module tb_exec_sequencer;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        bp_wr;
    logic [31:0] bp_addr;
    logic        bp_en_in;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        pc_en;
    logic        wr_gate;
    logic        halted;
    logic [1:0]  run_state;
    logic [2:0]  halt_cause;
    logic [31:0] retired_cnt;

    int checks   = 0;
    int failures = 0;

    exec_sequencer #(
        .ADDR_W       (32),
        .STEP_W       (8),
        .RUN_ON_RESET (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .bp_wr       (bp_wr),
        .bp_addr     (bp_addr),
        .bp_en_in    (bp_en_in),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .pc_en       (pc_en),
        .wr_gate     (wr_gate),
        .halted      (halted),
        .run_state   (run_state),
        .halt_cause  (halt_cause),
        .retired_cnt (retired_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_retired(input string tag, input logic [31:0] n);
`ifdef EXEC_SEQ_RETIRE_CNT_EN
        chk(tag, retired_cnt, n);
`else
        chk(tag, retired_cnt, 32'd0);
        if (n == 32'hFFFF_FFFF) chk("never", 32'd0, 32'd1);
`endif
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'd0;
        bp_wr = 1'b0; bp_addr = 32'd0; bp_en_in = 1'b0;
        pc_in = 32'd0; instr_in = NOP;

        // Reset state
        repeat (3) tick();
        reset = 1'b1;
        tick(); #1;
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_state", 32'(run_state), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        exp_retired("rst_retired", 32'd0);

        // Breakpoint at 0x10, run from PC 0
        bp_wr = 1'b1; bp_addr = 32'h10; bp_en_in = 1'b1;
        tick();
        bp_wr = 1'b0;
        cmd(2'b01, 8'd0);
        #1;
        chk("run_cmd_cycle_pc_en", 32'(pc_en), 32'd0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'(i * 4);
            #1;
            chk($sformatf("bp_commit_pc%0h", i * 4), 32'(pc_en), 32'd1);
            tick();
        end
        pc_in = 32'h10;
        #1;
        chk("bp_pc_en", 32'(pc_en), 32'd0);
        chk("bp_wr_gate", 32'(wr_gate), 32'd0);
        tick(); #1;
        chk("bp_halted", 32'(halted), 32'd1);
        chk("bp_cause", 32'(halt_cause), 32'd2);

        // Resume from the breakpoint PC: it commits once
        cmd(2'b01, 8'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("resume_bp_pc", 32'(pc_en), 32'd1);
        tick();
        pc_in = 32'h14;
        #1;
        chk("resume_next", 32'(pc_en), 32'd1);
        chk("resume_state", 32'(run_state), 32'd1);

        // Host HALT alone: current cycle commits, then cause HOST
        tick();
        pc_in = 32'h18;
        cmd(2'b00, 8'd0);
        #1;
        chk("host_halt_commit", 32'(pc_en), 32'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("host_halted", 32'(halted), 32'd1);
        chk("host_cause", 32'(halt_cause), 32'd1);
        exp_retired("retired_7", 32'd7);

        // Host HALT together with bp_hit: BP wins, no commit
        pc_in = 32'h20;
        cmd(2'b01, 8'd0);
        tick();
        cmd_valid = 1'b0;
        pc_in = 32'h24;
        tick();
        pc_in = 32'h10;
        cmd(2'b00, 8'd0);
        #1;
        chk("prio_pc_en", 32'(pc_en), 32'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("prio_cause", 32'(halt_cause), 32'd2);
        exp_retired("retired_8", 32'd8);

        // STEP 3: three pulses, not ready throughout, then STEP_DONE
        pc_in = 32'h40;
        cmd(2'b10, 8'd3);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h40 + 32'(i * 4);
            #1;
            chk($sformatf("step3_pulse%0d", i), 32'(pc_en), 32'd1);
            chk($sformatf("step3_ready%0d", i), 32'(cmd_ready), 32'd0);
            tick();
        end
        #1;
        chk("step3_pc_en_off", 32'(pc_en), 32'd0);
        chk("step3_cause", 32'(halt_cause), 32'd4);
        chk("step3_halted", 32'(halted), 32'd1);

        // STEP 0 behaves as STEP 1
        cmd(2'b10, 8'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("step0_pulse", 32'(pc_en), 32'd1);
        chk("step0_state", 32'(run_state), 32'd2);
        tick(); #1;
        chk("step0_done", 32'(halted), 32'd1);
        chk("step0_cause", 32'(halt_cause), 32'd4);
        exp_retired("retired_12", 32'd12);

        // CLR in HALT
        cmd(2'b11, 8'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("clr_cause", 32'(halt_cause), 32'd0);
        exp_retired("clr_retired", 32'd0);

        // EBREAK at PC 0x20 during RUN
        pc_in = 32'h1C;
        cmd(2'b01, 8'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("ebreak_pre_commit", 32'(pc_en), 32'd1);
        tick();
        pc_in = 32'h20; instr_in = EBREAK;
        #1;
        chk("ebreak_pc_en", 32'(pc_en), 32'd0);
        chk("ebreak_wr_gate", 32'(wr_gate), 32'd0);
        tick();
        instr_in = NOP;
        #1;
        chk("ebreak_halted", 32'(halted), 32'd1);
        chk("ebreak_cause", 32'(halt_cause), 32'd3);
        exp_retired("ebreak_retired", 32'd1);

        // Reset mid-step with counter 5
        pc_in = 32'h100;
        cmd(2'b10, 8'd5);
        tick();
        cmd_valid = 1'b0;
        tick();
        #1;
        chk("midstep_state", 32'(run_state), 32'd2);
        reset = 1'b0;
        #1;
        chk("midstep_rst_halted", 32'(halted), 32'd1);
        chk("midstep_rst_pc_en", 32'(pc_en), 32'd0);
        chk("midstep_rst_cause", 32'(halt_cause), 32'd0);
        exp_retired("midstep_rst_retired", 32'd0);
        tick();
        reset = 1'b1;
        tick(); #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Run-control sequencer for the single-cycle core.
- Decides each cycle whether the fetched instruction commits, i.e. whether the PC advances and register-file writes are allowed.
- Supports host run/halt/step commands, one hardware PC breakpoint, and EBREAK trapping.
- Sits between the IFU/control path and a host debug interface. Its pc_en gates the PC register; its wr_gate is ANDed with the decoded regwrite.

Parameters:
- ADDR_W, 32, width of PC and breakpoint address.
- STEP_W, 8, width of the step-count argument.
- RUN_ON_RESET, 0, 1 = leave reset in RUN; 0 = leave reset in HALT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  host command accept.
- cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 CLR.
- cmd_arg  in  STEP_W  step count for STEP.
- bp_wr  in  1  load breakpoint registers this cycle.
- bp_addr  in  ADDR_W  breakpoint PC.
- bp_en_in  in  1  breakpoint enable value to load.
- pc_in  in  ADDR_W  current PC from IFU.
- instr_in  in  32  current instruction word.
- pc_en  out  1  commit/advance enable to IFU.
- wr_gate  out  1  register-write qualifier (equals pc_en).
- halted  out  1  state == HALT.
- run_state  out  2  00 HALT, 01 RUN, 10 STEP.
- halt_cause  out  3  0 NONE, 1 HOST, 2 BP, 3 EBREAK, 4 STEP_DONE.
- retired_cnt  out  32  committed-instruction count (optional feature).

Behaviour:
- Reset (reset low, asynchronous):
  - run_state = RUN if RUN_ON_RESET, else HALT.
  - halt_cause = NONE; breakpoint disabled, bp address 0; step counter 0; skip flag 0; retired_cnt 0.
- Handshake:
  - A command transfers on a rising edge with cmd_valid and cmd_ready both high.
  - cmd_ready = 1 in HALT and RUN, 0 in STEP.
  - A host cannot issue a command during a step burst; it waits for HALT.
- Derived signals (combinational, same cycle):
  - ebreak_hit = (instr_in == 32'h0010_0073).
  - bp_hit = bp_en & (pc_in == bp_q) & ~skip.
- pc_en (combinational):
  - 1 in RUN or STEP when neither ebreak_hit nor bp_hit is set.
  - 0 in HALT.
  - A halting instruction does not commit.
- HALT state:
  - RUN cmd: go to RUN; set skip = 1; halt_cause = NONE.
  - STEP cmd: go to STEP; load counter with cmd_arg (0 treated as 1); set skip = 1; halt_cause = NONE.
  - CLR cmd: halt_cause = NONE; retired_cnt = 0.
  - HALT cmd: no-op.
- RUN state:
  - Priority: ebreak_hit, then bp_hit, then host HALT cmd.
  - ebreak_hit or bp_hit: go to HALT with cause EBREAK or BP.
  - Host HALT accepted: the current cycle still commits (pc_en unaffected); HALT entered next edge with cause HOST.
  - RUN, STEP and CLR cmds in RUN: accepted and ignored.
- STEP state:
  - Each committed cycle decrements the counter.
  - Commit with counter == 1: go to HALT, cause STEP_DONE.
  - ebreak_hit or bp_hit: go to HALT with that cause; the counter is discarded.
- Skip flag: cleared after the first cycle with pc_en = 1, so resuming from a breakpoint PC executes that instruction once.
- Breakpoint write: bp_wr is accepted in any state. A write's new value is used from the next cycle; the current cycle compares against the old value.
- retired_cnt wraps modulo 2^32.

Optional Feature:
- Macro: EXEC_SEQ_RETIRE_CNT_EN.
- Defined: retired_cnt increments on every cycle with pc_en = 1. CLR in HALT zeroes it; reset zeroes it.
- Undefined: the counter is not built; retired_cnt is tied to 0; CLR affects halt_cause only.

Decomposition:
- Shared package holds:
  - run_state encodings and halt_cause encodings;
  - cmd_op encodings;
  - the EBREAK_INSN constant (32'h0010_0073).
- One sub-module, exec_bp_unit: breakpoint address/enable registers, skip flag and bp_hit compare. The FSM, step counter and retire counter stay in the top.

Test Plan:
- Reset behaviour: RUN_ON_RESET=0, deassert reset -> halted=1, pc_en=0, halt_cause=0. Host RUN -> pc_en=1 from the next cycle.
- Breakpoint: set bp 0x0000_0010, RUN with PC stepping by 4 from 0 -> pc_en=1 for PCs 0,4,8,C and 0 at 0x10; halted with cause 2 the next cycle. RUN again -> 0x10 commits once, then execution continues.
- Step count: STEP with cmd_arg=3 from HALT -> exactly 3 pc_en pulses, cmd_ready=0 throughout, then HALT with cause 4. Repeat with cmd_arg=0 -> exactly 1 pulse.
- EBREAK trap: instr_in=0x0010_0073 at PC 0x20 during RUN -> pc_en=0 and wr_gate=0 that cycle; next cycle halted with cause 3.
- Priority: in RUN, host HALT in the same cycle as bp_hit -> cause 2, and the bp instruction does not commit. Host HALT alone -> the current cycle commits, then cause 1.
- Reset mid-step: assert reset during STEP with counter 5 -> immediately HALT, pc_en=0, and retired_cnt=0 (with EXEC_SEQ_RETIRE_CNT_EN).
